muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit for the execute stage of the MIPS datapath. Generalises the existing fixed 16-bit shift-add multiplier:
- configurable operand width;
- signed/unsigned mode;
- a `start`/`done`/`idle` handshake that runs on the system clock;
- optional restoring division, compiled in or out.

It produces a double-width product, or a quotient and remainder, which the datapath muxes onto the ALU result path.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be at least 4.
- `clock`, input, 1: system clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high. Forces IDLE and clears all registers.
- `start`, input, 1: request a new operation. Sampled only in IDLE.
- `op`, input, 1: 0 selects multiply, 1 selects divide.
- `sign_mode`, input, 1: 1 treats operands as two's complement.
- `operand_a`, input, `WIDTH`: multiplicand, or dividend.
- `operand_b`, input, `WIDTH`: multiplier, or divisor.
- `result_lo`, output, `WIDTH`: product low half, or quotient.
- `result_hi`, output, `WIDTH`: product high half, or remainder.
- `done`, output, 1: one-cycle pulse; results are valid from this cycle.
- `idle`, output, 1: high in IDLE only.
- `div_by_zero`, output, 1: valid with `done`; held until the next accepted start.

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- **IDLE, `start`=1:**
  - Latch `op` and `sign_mode`.
  - Latch the operand magnitudes (absolute values if `sign_mode`=1, otherwise raw).
  - Latch the result sign flags.
  - Clear the iteration counter. Go to CALC.
- **IDLE, `start`=0:** stay in IDLE.
- **CALC:** one radix-2 iteration per cycle, for exactly `WIDTH` cycles. The counter runs 0..`WIDTH`-1 and the FSM goes to FIXUP on the last count.
  - Multiply: shift-add over a 2·`WIDTH` accumulator.
  - Divide: restoring shift-subtract over a `WIDTH`+1-bit partial remainder.
- **FIXUP:** apply sign correction, then go to DONE.
  - Product sign = sign(a) XOR sign(b), negated over the full 2·`WIDTH` bits.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- **DONE:** `done`=1 for this single cycle. Go to IDLE.
- **Results:** `result_lo`/`result_hi` are written only in FIXUP. They hold their value until the FIXUP of the next operation.
- **`start` outside IDLE:** ignored. It is not queued.
- **Operand inputs after acceptance:** don't-care.
- **Divide by zero (`operand_b`=0):**
  - Same latency as a normal divide.
  - `result_lo` = all ones; `result_hi` = the original `operand_a` bit pattern. Both hold regardless of `sign_mode`.
  - `div_by_zero`=1.
- **Signed overflow (most-negative / -1):** `result_lo` = most-negative value, `result_hi` = 0, `div_by_zero`=0. This is the natural wrap; it is not flagged.
- **Multiply:** `div_by_zero` is always 0.
- **Reset, including mid-operation:**
  - Goes to IDLE immediately and asynchronously.
  - `result_lo`=0, `result_hi`=0, `done`=0, `div_by_zero`=0, `idle`=1.
  - The in-flight operation is discarded and no `done` is produced.

## Timing
- Start accepted at edge E0. CALC occupies the cycles after E0..E`WIDTH`, FIXUP follows E`WIDTH`, and `done`=1 in the cycle after E`WIDTH`+1.
- Latency: `done` rises `WIDTH`+2 cycles after acceptance, which is 18 for `WIDTH`=16.
- `idle` falls in the cycle after E0 and rises again in the cycle after `done`.
- Minimum start-to-start spacing: `WIDTH`+3 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `MULDIV_DIVIDE_EN`.
- **Defined:**
  - `op`=1 performs division as specified above.
- **Undefined:**
  - The divider datapath is absent.
  - `op` is ignored and every operation is a multiply.
  - `div_by_zero` is tied to 0.
  - Latency is unchanged.

## Test plan
All scenarios use `WIDTH`=16.
- **Unsigned multiply:** `op`=0, `sign_mode`=0, a=3, b=5 → `done` exactly 18 cycles after acceptance; `result_lo`=0x000F, `result_hi`=0x0000. Then a=0xFFFF, b=0xFFFF → `result_hi`=0xFFFE, `result_lo`=0x0001.
- **Signed multiply:** `sign_mode`=1, a=0xFFFD (-3), b=5 → `result_hi`=0xFFFF, `result_lo`=0xFFF1.
- **Divide (`MULDIV_DIVIDE_EN` defined):**
  - 100/7 unsigned → `result_lo`=14, `result_hi`=2.
  - Signed 0xFF9C (-100)/7 → `result_lo`=0xFFF2, `result_hi`=0xFFFE.
  - 0x8000/0xFFFF signed → `result_lo`=0x8000, `result_hi`=0.
- **Divide by zero:** a=0x1234, b=0 → `result_lo`=0xFFFF, `result_hi`=0x1234, `div_by_zero`=1 with `done`. A following multiply clears `div_by_zero`.
- **Handshake:**
  - Pulse `start` again at cycles 5 and 17 of a running operation → exactly one `done`, and the results match the first operands.
  - Hold `start` high continuously → operations spaced exactly 19 cycles apart.
- **Reset mid-operation:** assert `reset` at CALC iteration 8 → `idle`=1 and results 0 immediately, with no `done`. A new start after deassertion completes normally. Build without `MULDIV_DIVIDE_EN` and apply `op`=1, a=6, b=7 → `result_lo`=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 shift-add multiplier / restoring divider
// Division is built only when MULDIV_DIVIDE_EN is defined; otherwise op is ignored.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             done,
  output logic             idle,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_prod;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result_lo;
  logic [WIDTH-1:0]   r_result_hi;

  logic               w_accept;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div_req;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_calc_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [WIDTH-1:0]   w_fix_hi;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_sign_a = sign_mode & operand_a[WIDTH-1];
  assign w_sign_b = sign_mode & operand_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -operand_a : operand_a;
  assign w_mag_b  = w_sign_b ? -operand_b : operand_b;

  // Multiply: {hi, lo} accumulator, multiplier consumed from lo[0], carry kept in the shift.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod_fix = r_neg_prod ? -r_acc : r_acc;

`ifdef MULDIV_DIVIDE_EN
  logic               r_div;
  logic               r_dbz_pend;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_raw_a;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_unused_div;

  // Divide: {rem, quotient} share the accumulator; rem < divisor so W bits suffice.
  assign w_div_req   = op;
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_mcand};
  assign w_div_step  = w_div_diff[WIDTH+1]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_unused_div = w_div_diff[WIDTH];
  assign w_calc_next  = r_div ? w_div_step : w_mul_step;

  assign w_quot   = r_neg_prod ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_lo = !r_div ? w_prod_fix[WIDTH-1:0]
                  : (r_dbz_pend ? {WIDTH{1'b1}} : w_quot);
  assign w_fix_hi = !r_div ? w_prod_fix[2*WIDTH-1:WIDTH]
                  : (r_dbz_pend ? r_raw_a : w_rem);
  assign div_by_zero = r_dbz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div      <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_dbz      <= 1'b0;
      r_raw_a    <= '0;
    end else if (w_accept) begin
      r_div      <= op;
      r_dbz_pend <= op && (operand_b == '0);
      r_dbz      <= 1'b0;
      r_raw_a    <= operand_a;
    end else if (r_state == S_FIXUP) begin
      r_dbz      <= r_dbz_pend;
    end
  end
`else
  logic w_unused_op;

  assign w_unused_op = op;
  assign w_div_req   = 1'b0;
  assign w_calc_next = w_mul_step;
  assign w_fix_lo    = w_prod_fix[WIDTH-1:0];
  assign w_fix_hi    = w_prod_fix[2*WIDTH-1:WIDTH];
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_neg_prod  <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_result_lo <= '0;
      r_result_hi <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_neg_prod <= w_sign_a ^ w_sign_b;
            r_neg_rem  <= w_sign_a;
            r_mcand    <= w_div_req ? w_mag_b : w_mag_a;
            r_acc      <= w_div_req ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_calc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          r_result_lo <= w_fix_lo;
          r_result_hi <= w_fix_hi;
          r_state     <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result_lo = r_result_lo;
  assign result_hi = r_result_hi;
  assign done      = (r_state == S_DONE);
  assign idle      = (r_state == S_IDLE);

endmodule
